// File: rtl/multi_port_register_file.sv
// multi_port_register_file: 2-write / N-read register file with busy scoreboard and zero register.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data and busy state to the read ports.
module multi_port_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_READ_PORTS = 2,
    localparam int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [1:0]                           wr_en,
    input  logic [2*ADDR_WIDTH-1:0]              wr_addr,
    input  logic [2*DATA_WIDTH-1:0]              wr_data,
    input  logic                                 rsv_en,
    input  logic [ADDR_WIDTH-1:0]                rsv_addr,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ_PORTS-1:0]            rd_busy,
    output logic [REG_COUNT-1:0]                 busy_vec
);
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;

    // Port 1 is processed last so its write wins; the reserve is last so it beats any clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                    regs[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                    busy[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] <= 1'b0;
                end
            end
            if (rsv_en && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
        end
    end

    assign busy_vec = busy;

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] d;
        logic                  b;
        assign a = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        always_comb begin
            d = (a == '0) ? '0 : regs[a];
            b = (a == '0) ? 1'b0 : busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < 2; p++) begin
                if (!rst && wr_en[p] && a != '0 && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == a) begin
                    d = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
                    b = rsv_en && rsv_addr == a;
                end
            end
`endif
        end
        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = d;
        assign rd_busy[k] = b;
    end
endmodule
